// File: rtl/inst_fetch_unit.sv
// Purpose : instruction fetch with a DEPTH-entry prefetch FIFO feeding decode.
// Latency : issue edge -> push edge -> ir_valid; 2 edges from issue to head when empty.
// Backpres: issues stop when FIFO entries plus the outstanding read reach DEPTH; head holds while ir_ready=0.
//
// Ports:
//   CLOCK_50, KEY0              clock, async active-low reset
//   fetch_en                    allow new fetches
//   imem_addr / imem_rdata      synchronous instruction memory (data one cycle after address)
//   redirect_valid/redirect_pc  flush and restart fetch
//   ir_valid/ir_ready/ir_data/ir_pc  head of prefetch FIFO to decode
//   fifo_count                  FIFO occupancy 0..DEPTH
module inst_fetch_unit #(
   parameter int         DEPTH    = 4,
   parameter logic [9:0] RESET_PC = 10'd0
) (
   input  logic        CLOCK_50,
   input  logic        KEY0,
   input  logic        fetch_en,
   output logic [9:0]  imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [9:0]  redirect_pc,
   output logic        ir_valid,
   input  logic        ir_ready,
   output logic [31:0] ir_data,
   output logic [9:0]  ir_pc,
   output logic [2:0]  fifo_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [9:0]    fetch_pc;
   logic [9:0]    inflight_pc;
   logic          inflight;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [2:0]    count;
   logic [31:0]   mem_data [DEPTH];
   logic [9:0]    mem_pc   [DEPTH];

   logic       issue;
   logic       push;
   logic       pop;
   logic [3:0] occupancy;

   // The outstanding read reserves a slot so its response always has room;
   // a pop on the same edge deliberately does not free a slot for issue.
   assign occupancy = {1'b0, count} + {3'b000, inflight};
   assign issue     = fetch_en && !redirect_valid && (occupancy < 4'(DEPTH));
   assign push      = inflight && !redirect_valid;
   // On a redirect edge the head is still handed to decode, but the flush
   // below resets the pointers, so pop only matters on non-redirect edges.
   assign pop       = ir_valid && ir_ready && !redirect_valid;

   always_ff @(posedge CLOCK_50 or negedge KEY0) begin
      if (!KEY0) begin
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
      end else if (redirect_valid) begin
         // Flush everything, including the response still on its way back.
         fetch_pc <= redirect_pc;
         inflight <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         inflight <= issue;
         if (issue) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + 10'd1;
         end
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            count <= count + 3'd1;
         else if (pop && !push)
            count <= count - 3'd1;
      end
   end

   // Storage needs no reset: entries are only visible through count.
   always_ff @(posedge CLOCK_50) begin
      if (push) begin
         mem_data[wr_ptr] <= imem_rdata;
         mem_pc[wr_ptr]   <= inflight_pc;
      end
   end

   assign imem_addr  = fetch_pc;
   assign fifo_count = count;
   assign ir_valid   = (count != 3'd0);
   assign ir_data    = ir_valid ? mem_data[rd_ptr] : '0;
   assign ir_pc      = ir_valid ? mem_pc[rd_ptr]   : '0;

   // The issue throttle must make an overflowing push impossible.
   a_no_push_when_full : assert property (
      @(posedge CLOCK_50) disable iff (!KEY0) push |-> (count != 3'(DEPTH)));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed phases with a scoreboard of expected
// fetch addresses, popped on every observed transfer to decode.
module tb_inst_fetch_unit;

   localparam logic [9:0] RST_PC = 10'h100;

   logic        CLOCK_50 = 1'b0;
   logic        KEY0 = 1'b0;
   logic        fetch_en = 1'b0;
   logic [9:0]  imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        redirect_valid = 1'b0;
   logic [9:0]  redirect_pc = '0;
   logic        ir_valid;
   logic        ir_ready = 1'b0;
   logic [31:0] ir_data;
   logic [9:0]  ir_pc;
   logic [2:0]  fifo_count;

   inst_fetch_unit #(.DEPTH(4), .RESET_PC(RST_PC)) dut (
      .CLOCK_50       (CLOCK_50),
      .KEY0           (KEY0),
      .fetch_en       (fetch_en),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .ir_valid       (ir_valid),
      .ir_ready       (ir_ready),
      .ir_data        (ir_data),
      .ir_pc          (ir_pc),
      .fifo_count     (fifo_count)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // Memory content: word = salt | address.
   logic [31:0] salt = '0;
   function automatic logic [31:0] word(input logic [9:0] a);
      return salt | {22'd0, a};
   endfunction

   always @(posedge CLOCK_50) imem_rdata <= word(imem_addr);

   int n_pass  = 0;
   int n_total = 0;
   int n_xfer  = 0;
   int base    = 0;
   logic [9:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic sample();
      @(negedge CLOCK_50);
      #1;
   endtask

   task automatic push_seq(input logic [9:0] start, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(start + 10'(i));
   endtask

   // Transfer monitor plus stall-stability check.
   logic        held_vld = 1'b0;
   logic [9:0]  held_pc = '0;
   logic [31:0] held_data = '0;
   always @(negedge CLOCK_50) begin
      logic [9:0] e;
      if (held_vld && ir_valid) begin
         check("stall_pc", 32'(ir_pc), 32'(held_pc));
         check("stall_data", ir_data, held_data);
      end
      if (KEY0 && ir_valid && ir_ready) begin
         n_xfer++;
         check("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("xfer_pc", 32'(ir_pc), 32'(e));
            check("xfer_data", ir_data, word(e));
         end
      end
      held_vld  = KEY0 && ir_valid && !ir_ready && !redirect_valid;
      held_pc   = ir_pc;
      held_data = ir_data;
   end

   initial begin
      logic [9:0] wrap_exp [4];
      wrap_exp = '{10'd1022, 10'd1023, 10'd0, 10'd1};

      // Reset state
      repeat (2) step();
      check("rst_vld", 32'(ir_valid), 32'd0);
      check("rst_data", ir_data, 32'd0);
      check("rst_pc", 32'(ir_pc), 32'd0);
      check("rst_count", 32'(fifo_count), 32'd0);
      check("rst_addr", 32'(imem_addr), 32'(RST_PC));

      // Free-running after release: 2-edge latency, then one per cycle
      KEY0 = 1'b1; fetch_en = 1'b1; ir_ready = 1'b1;
      push_seq(RST_PC, 40);
      sample();
      check("rel_vld", 32'(ir_valid), 32'd0);
      check("rel_addr", 32'(imem_addr), 32'(RST_PC));
      step(); sample();
      check("e1_vld", 32'(ir_valid), 32'd0);
      check("e1_addr", 32'(imem_addr), 32'(RST_PC + 10'd1));
      step(); sample();
      check("e2_vld", 32'(ir_valid), 32'd1);
      check("e2_pc", 32'(ir_pc), 32'(RST_PC));
      check("e2_data", ir_data, word(RST_PC));
      base = n_xfer;
      repeat (18) step();
      sample();
      check("run_xfers", 32'(n_xfer - base), 32'd18);
      check("run_pc", 32'(ir_pc), 32'(RST_PC + 10'd18));

      // Async reset mid-run, then fill with decode stalled
      KEY0 = 1'b0; #1;
      check("arst_vld", 32'(ir_valid), 32'd0);
      check("arst_count", 32'(fifo_count), 32'd0);
      exp_q.delete();
      ir_ready = 1'b0;
      step();
      KEY0 = 1'b1;
      push_seq(RST_PC, 40);
      repeat (8) step();
      sample();
      check("full_count", 32'(fifo_count), 32'd4);
      check("full_addr", 32'(imem_addr), 32'(RST_PC + 10'd4));
      check("full_vld", 32'(ir_valid), 32'd1);
      check("full_pc", 32'(ir_pc), 32'(RST_PC));
      check("full_data", ir_data, word(RST_PC));
      step();
      ir_ready = 1'b1;
      base = n_xfer;
      repeat (11) step();
      sample();
      check("drain_xfers", 32'(n_xfer - base), 32'd12);
      check("drain_pc", 32'(ir_pc), 32'(RST_PC + 10'd11));

      // Redirect with count=3, inflight=1, head accepted on the redirect edge
      KEY0 = 1'b0;
      exp_q.delete();
      salt = 32'h5A5A_0000;
      ir_ready = 1'b0;
      step();
      KEY0 = 1'b1;
      push_seq(RST_PC, 4);
      repeat (4) step();
      redirect_valid = 1'b1; redirect_pc = 10'h200; ir_ready = 1'b1;
      sample();
      check("pre_redir_count", 32'(fifo_count), 32'd3);
      check("pre_redir_pc", 32'(ir_pc), 32'(RST_PC));
      step();
      redirect_valid = 1'b0;
      exp_q.delete();
      push_seq(10'h200, 16);
      sample();
      check("redir_count", 32'(fifo_count), 32'd0);
      check("redir_vld", 32'(ir_valid), 32'd0);
      check("redir_addr", 32'(imem_addr), 32'h200);
      step(); sample();
      check("redir_e1_vld", 32'(ir_valid), 32'd0);
      check("redir_e1_addr", 32'(imem_addr), 32'h201);
      step(); sample();
      check("redir_e2_vld", 32'(ir_valid), 32'd1);
      check("redir_e2_pc", 32'(ir_pc), 32'h200);
      check("redir_e2_data", ir_data, word(10'h200));

      // fetch_en=0: no new issue, but the outstanding response still lands
      repeat (4) step();
      fetch_en = 1'b0; ir_ready = 1'b0;
      repeat (2) step();
      sample();
      check("fen0_count", 32'(fifo_count), 32'd2);
      check("fen0_addr", 32'(imem_addr), 32'h206);

      // Redirect near the top of the address space: wrap 1023 -> 0
      step();
      fetch_en = 1'b1; ir_ready = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 10'd1022;
      step();
      redirect_valid = 1'b0;
      exp_q.delete();
      push_seq(10'd1022, 12);
      step(); step(); sample();
      check("wrap_pc0", 32'(ir_pc), 32'(wrap_exp[0]));
      for (int i = 1; i < 4; i++) begin
         step(); sample();
         check("wrap_pc", 32'(ir_pc), 32'(wrap_exp[i]));
      end

      // Async reset with FIFO full, then restart at RESET_PC
      step();
      ir_ready = 1'b0;
      repeat (6) step();
      sample();
      check("full2_count", 32'(fifo_count), 32'd4);
      KEY0 = 1'b0; #1;
      check("arst2_vld", 32'(ir_valid), 32'd0);
      check("arst2_data", ir_data, 32'd0);
      check("arst2_pc", 32'(ir_pc), 32'd0);
      check("arst2_count", 32'(fifo_count), 32'd0);
      check("arst2_addr", 32'(imem_addr), 32'(RST_PC));
      exp_q.delete();
      step();
      KEY0 = 1'b1; ir_ready = 1'b1;
      push_seq(RST_PC, 20);
      step(); step(); sample();
      check("restart_vld", 32'(ir_valid), 32'd1);
      check("restart_pc", 32'(ir_pc), 32'(RST_PC));
      repeat (5) step();
      sample();
      check("restart_run_pc", 32'(ir_pc), 32'(RST_PC + 10'd5));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 The block SHALL have these parameters, one per line as name, default, meaning:
  DEPTH, 4, prefetch FIFO entries (power of two, at least 2)
  RESET_PC, 10'd0, first fetch address after reset
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
  CLOCK_50  in  1  sole clock; all state updates on its rising edge
  KEY0  in  1  asynchronous active-low reset
  fetch_en  in  1  1 = issue new fetches; 0 = stop issuing
  imem_addr  out  10  instruction memory address (synchronous read, data valid one cycle later)
  imem_rdata  in  32  instruction memory read data
  redirect_valid  in  1  1 = flush and restart fetch at redirect_pc
  redirect_pc  in  10  restart address
  ir_valid  out  1  FIFO head valid to decode stage
  ir_ready  in  1  decode stage accepts head
  ir_data  out  32  head instruction word
  ir_pc  out  10  address of head instruction
  fifo_count  out  3  FIFO occupancy, 0..DEPTH
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-low (KEY0 = 0 resets).

Function
REQ-004 The block SHALL keep a 10-bit fetch_pc register; imem_addr SHALL equal fetch_pc combinationally.
REQ-005 An issue SHALL occur in any cycle where fetch_en=1, redirect_valid=0 and (fifo_count + inflight) < DEPTH; pops in the same cycle SHALL NOT count toward this test.
REQ-006 On an issue edge: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+1 mod 1024 (1023 wraps to 0). With no issue: inflight<=0, fetch_pc holds.
REQ-007 When inflight=1 and redirect_valid=0, the edge SHALL push {imem_rdata, inflight_pc} into the FIFO tail.
REQ-008 ir_valid SHALL be (fifo_count != 0); ir_data and ir_pc SHALL show the head entry, or 0 when empty.
REQ-009 A transfer SHALL occur on an edge where ir_valid=1 and ir_ready=1, and SHALL pop the head.
REQ-010 While ir_valid=1 and ir_ready=0, ir_data and ir_pc SHALL hold stable.
REQ-011 A simultaneous push and pop SHALL leave fifo_count unchanged. Read and write pointers SHALL wrap mod DEPTH.
REQ-012 A push SHALL never occur when the FIFO is full; REQ-005 guarantees this, and an assertion SHALL check it.
REQ-013 redirect_valid=1 SHALL take priority over all other events on that edge: FIFO emptied (count 0, pointers 0), inflight<=0 (pending response discarded), fetch_pc<=redirect_pc, no issue and no push.
REQ-014 On a redirect edge with ir_valid=1 and ir_ready=1, the head SHALL count as transferred to decode; it is then flushed along with the rest.
REQ-015 The first issue after a redirect SHALL be at redirect_pc, on the following cycle if enabled.
REQ-016 fetch_en=0 SHALL block new issues only; a pending inflight response SHALL still be pushed.
REQ-017 Latency from issue to ir_valid SHALL be exactly 2 edges when the FIFO is empty: issue edge, then push edge.
REQ-018 With ir_ready and fetch_en held at 1, steady-state throughput SHALL be one instruction per cycle.

Reset
REQ-019 KEY0=0 SHALL immediately, without waiting for a clock edge, force: fetch_pc=RESET_PC, inflight=0, FIFO empty, ir_valid=0, ir_data=0, ir_pc=0, fifo_count=0, imem_addr=RESET_PC.
REQ-020 Reset asserted mid-operation SHALL discard all FIFO and inflight contents.
REQ-021 The first issue after reset release SHALL be at the first rising edge with KEY0=1 and fetch_en=1.

Verification
REQ-022 Reset release with fetch_en=1, ir_ready=1, memory word = address: ir_valid rises after edge 2 with ir_pc=0, ir_data=0, then ir_pc 1,2,3… on consecutive cycles.
REQ-023 ir_ready=0 from reset: fifo_count reaches 4 and stays; imem_addr stops at 4; ir_data=0 stays stable; raising ir_ready drains 0..3 then continues at 4.
REQ-024 Redirect to 10'h200 while fifo_count=3 and inflight=1: next cycle fifo_count=0, ir_valid=0, imem_addr=10'h200; the old inflight word is never output; 10'h200 appears 2 edges later.
REQ-025 redirect_pc=10'd1022, free-running: ir_pc sequence is 1022, 1023, 0, 1.
REQ-026 KEY0 pulsed low asynchronously with FIFO full: all outputs are 0 and imem_addr=RESET_PC before the next edge, and fetch restarts at RESET_PC after release.
